// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection controller board and the phase scheduler:
// 1 Hz pacing, demand/police inputs, light codes, BCD countdowns and phase status.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       A_Traffic;
  logic       B_Traffic;
  logic       Police_A;
  logic       Police_B;
  logic [1:0] A_Light;
  logic [1:0] B_Light;
  logic [3:0] A_Time_H;
  logic [3:0] A_Time_L;
  logic [3:0] B_Time_H;
  logic [3:0] B_Time_L;
  logic [3:0] phase;

  modport master (
    output tick, A_Traffic, B_Traffic, Police_A, Police_B,
    input  A_Light, B_Light, A_Time_H, A_Time_L, B_Time_H, B_Time_L, phase
  );

  modport slave (
    input  tick, A_Traffic, B_Traffic, Police_A, Police_B,
    output A_Light, B_Light, A_Time_H, A_Time_L, B_Time_H, B_Time_L, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer: green/yellow/all-red cycling with demand extension and skip,
// idle wink mode, police pre-emption, and registered light codes plus BCD countdowns.
module traffic_phase_scheduler #(
  parameter int GREEN_A = 25,
  parameter int GREEN_B = 25,
  parameter int YELLOW  = 5,
  parameter int ALLRED  = 2,
  parameter int EXT     = 10,
  parameter int MAX_EXT = 2
) (
  input logic                      Clk,
  input logic                      R,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_A_GRN  = 4'd1;
  localparam logic [3:0] S_A_YEL  = 4'd2;
  localparam logic [3:0] S_AR_AB  = 4'd3;
  localparam logic [3:0] S_B_GRN  = 4'd4;
  localparam logic [3:0] S_B_YEL  = 4'd5;
  localparam logic [3:0] S_AR_BA  = 4'd6;
  localparam logic [3:0] S_WINK   = 4'd7;
  localparam logic [3:0] S_POLICE = 4'd8;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

  localparam logic [6:0] GREEN_A_C = 7'(GREEN_A);
  localparam logic [6:0] GREEN_B_C = 7'(GREEN_B);
  localparam logic [6:0] YELLOW_C  = 7'(YELLOW);
  localparam logic [6:0] ALLRED_C  = 7'(ALLRED);
  localparam logic [6:0] EXT_C     = 7'(EXT);
  localparam logic [6:0] MAX_EXT_C = 7'(MAX_EXT);

  localparam logic [8:0] GA9 = 9'(GREEN_A);
  localparam logic [8:0] GB9 = 9'(GREEN_B);
  localparam logic [8:0] Y9  = 9'(YELLOW);
  localparam logic [8:0] AR9 = 9'(ALLRED);

  // Saturate at 99 and split into {tens, units} BCD digits.
  function automatic logic [7:0] to_bcd(input logic [8:0] v);
    logic [8:0] s;
    s = (v > 9'd99) ? 9'd99 : v;
    return {4'(s / 9'd10), 4'(s % 9'd10)};
  endfunction

  localparam logic [7:0] A_TIME_RST = to_bcd(AR9);
  localparam logic [7:0] B_TIME_RST = to_bcd(AR9 + GA9 + Y9 + AR9);

  logic [3:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] ext_used_q, ext_used_d;
  logic       target_q, target_d;     // police target road: 0 = A, 1 = B
  logic       wink_off_q, wink_off_d;
  logic [1:0] a_light_q, a_light_d, b_light_q, b_light_d;
  logic [7:0] a_time_q, a_time_d, b_time_q, b_time_d;

  logic police_req, req_tgt, tick_end, on_b, own_tr, other_tr, a_wins, b_wins;
  logic [8:0] cnt9, a_bin, b_bin;

  assign police_req = bus.Police_A | bus.Police_B;
  assign req_tgt    = ~bus.Police_A;
  assign tick_end   = bus.tick && (cnt_q == 7'd1);
  assign on_b       = (state_q == S_B_GRN) || (state_q == S_B_YEL);
  assign own_tr     = on_b ? bus.B_Traffic : bus.A_Traffic;
  assign other_tr   = on_b ? bus.A_Traffic : bus.B_Traffic;
  // After A->B clearance road B gets first claim; otherwise road A does.
  assign a_wins     = (state_q == S_AR_AB) ? (bus.A_Traffic & ~bus.B_Traffic) : bus.A_Traffic;
  assign b_wins     = (state_q == S_AR_AB) ? bus.B_Traffic : (bus.B_Traffic & ~bus.A_Traffic);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ext_used_d = ext_used_q;
    wink_off_d = wink_off_q;
    target_d   = police_req ? req_tgt : target_q;

    case (state_q)
      S_INIT, S_AR_BA, S_AR_AB: begin
        if (tick_end) begin
          if (police_req)  state_d = S_POLICE;
          else if (a_wins) begin state_d = S_A_GRN; cnt_d = GREEN_A_C; end
          else if (b_wins) begin state_d = S_B_GRN; cnt_d = GREEN_B_C; end
          else begin state_d = S_WINK; wink_off_d = 1'b0; end
        end else if (bus.tick) begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_A_GRN, S_B_GRN: begin
        if (police_req) begin
          ext_used_d = '0;
          if (req_tgt == on_b) state_d = S_POLICE;
          else begin state_d = on_b ? S_B_YEL : S_A_YEL; cnt_d = YELLOW_C; end
        end else if (tick_end) begin
          if (own_tr && !other_tr && (ext_used_q < MAX_EXT_C)) begin
            cnt_d      = EXT_C;
            ext_used_d = ext_used_q + 7'd1;
          end else begin
            state_d    = on_b ? S_B_YEL : S_A_YEL;
            cnt_d      = YELLOW_C;
            ext_used_d = '0;
          end
        end else if (bus.tick) begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_A_YEL, S_B_YEL: begin
        if (tick_end) begin
          state_d = on_b ? S_AR_BA : S_AR_AB;
          cnt_d   = ALLRED_C;
        end else if (bus.tick) begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_WINK: begin
        if (police_req || (bus.tick && (bus.A_Traffic || bus.B_Traffic))) begin
          state_d = S_AR_BA;
          cnt_d   = ALLRED_C;
        end else if (bus.tick) begin
          wink_off_d = ~wink_off_q;
        end
      end
      S_POLICE: begin
        // Hand the green road back through its yellow on release or retarget.
        if (!police_req || (req_tgt != target_q)) begin
          state_d = target_q ? S_B_YEL : S_A_YEL;
          cnt_d   = YELLOW_C;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = ALLRED_C;
      end
    endcase
  end

  // Outputs are decoded from next-state so the registered values track the phase directly.
  always_comb begin
    a_light_d = L_RED;
    b_light_d = L_RED;
    a_bin     = '0;
    b_bin     = '0;
    cnt9      = {2'b00, cnt_d};
    case (state_d)
      S_A_GRN:  begin a_light_d = L_GRN; a_bin = cnt9; b_bin = cnt9 + Y9 + AR9; end
      S_A_YEL:  begin a_light_d = L_YEL; a_bin = cnt9; b_bin = cnt9 + AR9; end
      S_AR_AB:  begin b_bin = cnt9; a_bin = cnt9 + GB9 + Y9 + AR9; end
      S_B_GRN:  begin b_light_d = L_GRN; b_bin = cnt9; a_bin = cnt9 + Y9 + AR9; end
      S_B_YEL:  begin b_light_d = L_YEL; b_bin = cnt9; a_bin = cnt9 + AR9; end
      S_INIT,
      S_AR_BA:  begin a_bin = cnt9; b_bin = cnt9 + GA9 + Y9 + AR9; end
      S_WINK:   begin
        a_light_d = wink_off_d ? L_OFF : L_YEL;
        b_light_d = wink_off_d ? L_OFF : L_YEL;
      end
      S_POLICE: begin
        if (target_d) b_light_d = L_GRN;
        else          a_light_d = L_GRN;
      end
      default: ;
    endcase
    a_time_d = to_bcd(a_bin);
    b_time_d = to_bcd(b_bin);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q    <= S_INIT;
      cnt_q      <= ALLRED_C;
      ext_used_q <= '0;
      target_q   <= 1'b0;
      wink_off_q <= 1'b0;
      a_light_q  <= L_RED;
      b_light_q  <= L_RED;
      a_time_q   <= A_TIME_RST;
      b_time_q   <= B_TIME_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_used_q <= ext_used_d;
      target_q   <= target_d;
      wink_off_q <= wink_off_d;
      a_light_q  <= a_light_d;
      b_light_q  <= b_light_d;
      a_time_q   <= a_time_d;
      b_time_q   <= b_time_d;
    end
  end

  assign bus.A_Light  = a_light_q;
  assign bus.B_Light  = b_light_q;
  assign bus.A_Time_H = a_time_q[7:4];
  assign bus.A_Time_L = a_time_q[3:0];
  assign bus.B_Time_H = b_time_q[7:4];
  assign bus.B_Time_L = b_time_q[3:0];
  assign bus.phase    = state_q;

endmodule
